instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer between the PC logic and the word-addressed instruction memory.
//  Issues one read at a time, tolerating zero or more wait cycles, and buffers
//  results in a small prefetch FIFO feeding decode via valid/ready.
//  Handles branch redirects with flush and in-flight discard, and flags PCs that
//  fall outside the memory.
// PARAMETERS
//  ADDR_W      32  PC / byte-address width
//  DATA_W      32  instruction width
//  RESET_PC    0   first fetch address after reset
//  FIFO_DEPTH  2   prefetch entries; power of 2, >=2
//  INSTR_NUM   1024 memory size in words; PC>>2 >= INSTR_NUM is a fault
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       synchronous reset, active-low
//  redirect_i     in   1       branch/jump taken; restart fetch at redirect_pc_i
//  redirect_pc_i  in   ADDR_W  redirect target (bits[1:0] ignored)
//  mem_req_o      out  1       read request to instruction memory
//  mem_addr_o     out  ADDR_W  byte address, word aligned
//  mem_ack_i      in   1       read done; mem_rdata_i valid this cycle
//  mem_rdata_i    in   DATA_W  instruction word
//  out_valid_o    out  1       FIFO head valid
//  out_ready_i    in   1       decode accepts head
//  out_instr_o    out  DATA_W  head instruction
//  out_pc_o       out  ADDR_W  PC of head instruction
//  out_fault_o    out  1       head entry is out-of-range fault (instr = 0)
// BEHAVIOUR
//  Reset (rst_i=0 at edge): FIFO empty, fetch_pc=RESET_PC, state FETCH,
//   no request outstanding. While rst_i=0: out_valid_o=0, mem_req_o=0,
//   out_fault_o=0, out_instr_o=0, out_pc_o=0.
//  States:
//   FETCH   - idle or issuing.
//   WAIT    - request held, no ack yet.
//   DISCARD - redirect hit while request outstanding; wait for ack, drop data.
//   HALT    - fault entry pushed; no fetch until redirect.
//  Issue: mem_req_o=1 (combinational) in FETCH/WAIT/DISCARD when
//   slot reserved: occupancy (after this cycle's pop) < FIFO_DEPTH.
//   mem_addr_o=fetch_pc. addr and req held stable until mem_ack_i=1.
//   Max one outstanding.
//  Ack in FETCH/WAIT: push {rdata,fetch_pc,0}; fetch_pc+=4; stay FETCH.
//   No ack: WAIT.
//  Zero-wait memory, ready=1: 1 instr/cycle. First out_valid_o = 1 cycle after
//   the first cycle with rst_i=1.
//  Output: out_valid_o = FIFO not empty. Pop on valid & ready. Head fields stable
//   while valid & !ready. Push+pop same cycle legal; count unchanged.
//   Overflow impossible (slot reserved at issue); never push when full.
//  Fault: if fetch_pc>>2 >= INSTR_NUM in FETCH with space:
//   - no mem_req_o
//   - push {0,fetch_pc,1}
//   - go HALT
//  Redirect (highest priority):
//   - FIFO flushed at edge; any pop that cycle is void
//   - fetch_pc <= {redirect_pc_i[ADDR_W-1:2],2'b00}
//   - next state DISCARD if request outstanding and no ack this cycle, else FETCH
//   - ack same cycle as redirect: data dropped
//   - redirect in HALT: resume FETCH
//  DISCARD: mem_req_o held with old address; on ack drop data -> FETCH, new
//   fetch_pc. Second redirect in DISCARD updates fetch_pc only.
//  Wrap: fetch_pc+4 wraps modulo 2^ADDR_W. Range check applies first, so wrap
//   is only reached if INSTR_NUM covers the space.
//  Reset mid-operation: outstanding request abandoned; memory shares rst_i.
// TESTING
//  1 Reset release, zero-wait mem, ready=1 -> PCs 0,4,8.. one per cycle;
//    out_valid_o=1 from cycle 1.
//  2 ack delayed 3 cycles -> mem_addr_o stable 4 cycles; each instr appears
//    1 cycle after its ack.
//  3 ready=0 for 5 cycles -> FIFO fills to 2, mem_req_o=0, head PC held;
//    release -> order preserved, none lost or duplicated.
//  4 redirect to 0x40 while req to 0x8 pending -> DISCARD, 0x8 data dropped;
//    next out_pc_o=0x40, FIFO flushed.
//  5 redirect to 0x1000 (INSTR_NUM=1024) -> one entry, fault=1, instr=0,
//    no mem_req_o; HALT until redirect to 0x0 resumes.
//  6 rst_i=0 mid-WAIT -> next cycle outputs 0; after release fetch restarts
//    at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: single-outstanding memory reads into a small
// prefetch FIFO, with branch redirect flush, in-flight discard and range faults.
module instr_fetch_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter int unsigned       INSTR_NUM  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              out_fault_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic              fault;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];

    logic              fifo_empty;
    logic              pop;
    logic [CNT_W-1:0]  occ_after_pop;
    logic              has_space;
    logic              pc_out_of_range;
    logic              ack;
    logic              push_en;
    entry_t            push_entry;
    entry_t            head;

    // Memory-side handshake; a slot is reserved before a read is issued.
    always_comb begin
        fifo_empty      = (count_q == '0);
        pop             = !fifo_empty && out_ready_i;
        occ_after_pop   = count_q - CNT_W'(pop);
        has_space       = occ_after_pop < CNT_W'(FIFO_DEPTH);
        pc_out_of_range = 64'(fetch_pc_q[ADDR_W-1:2]) >= 64'(INSTR_NUM);
        mem_req_o       = rst_i && has_space &&
                          ((state_q == ST_FETCH && !pc_out_of_range) ||
                           state_q == ST_WAIT || state_q == ST_DISCARD);
        mem_addr_o      = (state_q == ST_DISCARD) ? disc_addr_q : fetch_pc_q;
        ack             = mem_req_o && mem_ack_i;
    end

    // Next-state: redirect overrides everything, then per-state sequencing.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_d      = fifo_q;
        push_en     = 1'b0;
        push_entry  = '0;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (mem_req_o && !mem_ack_i) begin
                state_d     = ST_DISCARD;
                disc_addr_d = mem_addr_o;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_req_o) begin
                        if (ack) begin
                            push_en    = 1'b1;
                            push_entry = '{instr: mem_rdata_i, pc: fetch_pc_q, fault: 1'b0};
                            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (pc_out_of_range && has_space) begin
                        push_en    = 1'b1;
                        push_entry = '{instr: '0, pc: fetch_pc_q, fault: 1'b1};
                        state_d    = ST_HALT;
                    end
                end
                ST_WAIT: begin
                    if (ack) begin
                        push_en    = 1'b1;
                        push_entry = '{instr: mem_rdata_i, pc: fetch_pc_q, fault: 1'b0};
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        state_d    = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (ack) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase

            if (push_en) begin
                fifo_d[wr_ptr_q] = push_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end

    // Head fields read as zero whenever nothing valid is presented.
    always_comb begin
        head        = fifo_q[rd_ptr_q];
        out_valid_o = rst_i && !fifo_empty;
        out_instr_o = out_valid_o ? head.instr : '0;
        out_pc_o    = out_valid_o ? head.pc    : '0;
        out_fault_o = out_valid_o && head.fault;
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios followed by random traffic,
// checked against an expected-PC-stream model and a latency-programmable memory.
module tb_instr_fetch_ctrl;

    localparam int unsigned INSTR_NUM = 1024;

    logic        clk_i;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_fault_o;

    instr_fetch_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2),
        .INSTR_NUM  (INSTR_NUM)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .out_fault_o   (out_fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    // Memory model state
    int lat_cfg = 0;
    bit lat_rand = 0;
    int wait_cnt = 0;
    int cur_lat = 0;

    // Expected instruction stream
    logic [31:0] exp_pc = 32'h0;
    bit          halted = 0;

    // Values observed in the most recent cycle
    logic        cap_req, cap_ack;
    logic [31:0] cap_addr;
    logic        prev_live = 0, prev_req = 0, prev_ack = 0;
    logic [31:0] prev_addr = '0;
    logic        prev_hold = 0;
    logic [31:0] prev_hp = '0, prev_hi = '0;
    logic        prev_hf = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, answer the memory, score pops at the edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic        pop, hv, hf, ef;
        logic [31:0] hp, hi;
        out_ready_i   = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        mem_ack_i     = 1'b0;
        #1;
        if (mem_req_o) begin
            if (wait_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
            if (wait_cnt >= cur_lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = instr_of(mem_addr_o);
            end
        end
        #1;
        cap_req  = mem_req_o;
        cap_addr = mem_addr_o;
        cap_ack  = mem_ack_i;
        hv = out_valid_o; hp = out_pc_o; hi = out_instr_o; hf = out_fault_o;
        if (rst_i && prev_live && prev_req && !prev_ack) begin
            chk("req_held", cap_req, 1);
            chk("addr_held", cap_addr, prev_addr);
        end
        if (rst_i && prev_live && prev_hold) begin
            chk("head_pc_stable", hp, prev_hp);
            chk("head_instr_stable", hi, prev_hi);
            chk("head_fault_stable", hf, prev_hf);
        end
        if (rst_i && halted) begin
            chk("halt_no_req", cap_req, 0);
            chk("halt_no_valid", hv, 0);
        end
        pop = rst_i && hv && rdy && !redir;
        @(posedge clk_i);
        if (pop) begin
            ef = (exp_pc >> 2) >= 32'(INSTR_NUM);
            chk("pop_pc", hp, exp_pc);
            chk("pop_fault", hf, ef);
            chk("pop_instr", hi, ef ? 32'h0 : instr_of(exp_pc));
            if (ef) halted = 1;
            else    exp_pc = exp_pc + 32'd4;
            accepted++;
        end
        if (!rst_i) begin
            exp_pc   = 32'h0;
            halted   = 0;
            wait_cnt = 0;
        end else begin
            if (redir) begin
                exp_pc = tgt & ~32'd3;
                halted = 0;
            end
            if (cap_req && cap_ack) wait_cnt = 0;
            else if (cap_req)       wait_cnt++;
        end
        prev_live = rst_i;
        prev_req  = cap_req;
        prev_ack  = cap_ack;
        prev_addr = cap_addr;
        prev_hold = hv && !rdy && !redir;
        prev_hp = hp; prev_hi = hi; prev_hf = hf;
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] a0, tgt, pend;
        bit          found;
        logic        rdy, redir;

        rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; out_ready_i = 1'b0;
        @(negedge clk_i);

        // Reset holds everything quiet
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_pc", out_pc_o, 0);
        chk("rst_instr", out_instr_o, 0);
        chk("rst_fault", out_fault_o, 0);
        chk("rst_req", cap_req, 0);

        // Zero-wait streaming, one instruction per cycle
        rst_i = 1'b1;
        chk("t1_valid_before", out_valid_o, 0);
        cycle(1, 0, 0);
        chk("t1_first_req", cap_req, 1);
        chk("t1_first_addr", cap_addr, 32'h0);
        chk("t1_valid_c1", out_valid_o, 1);
        chk("t1_pc_c1", out_pc_o, 32'h0);
        for (int i = 1; i < 4; i++) begin
            cycle(1, 0, 0);
            chk("t1_valid", out_valid_o, 1);
            chk("t1_pc", out_pc_o, 32'(4 * i));
        end

        // Three wait states: address held four cycles, data one cycle after ack
        lat_cfg = 3;
        cycle(1, 0, 0);
        a0 = cap_addr;
        chk("t2_addr", a0, 32'h10);
        chk("t2_ack0", cap_ack, 0);
        for (int i = 1; i < 4; i++) begin
            cycle(1, 0, 0);
            chk("t2_addr_stable", cap_addr, a0);
            chk("t2_ack", cap_ack, (i == 3) ? 1'b1 : 1'b0);
            if (i == 2) chk("t2_drained", out_valid_o, 0);
        end
        chk("t2_valid_after_ack", out_valid_o, 1);
        chk("t2_pc_after_ack", out_pc_o, a0);

        // Back-pressure fills the FIFO and stops issue
        lat_cfg = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0);
            chk("t3_head_pc", out_pc_o, 32'h10);
            chk("t3_valid", out_valid_o, 1);
            if (i >= 1) chk("t3_no_req", cap_req, 0);
        end
        cycle(1, 0, 0);
        chk("t3_next_pc", out_pc_o, 32'h14);
        cycle(1, 0, 0);
        cycle(1, 0, 0);

        // Redirect while a read is pending: pending data dropped, restart at 0x40
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1, 0, 0);
            if (cap_req && !cap_ack) found = 1;
        end
        chk("t4_pending_seen", found, 1);
        pend = cap_addr;
        cycle(1, 1, 32'h40);
        chk("t4_redirect_req", cap_req, 1);
        chk("t4_redirect_addr", cap_addr, pend);
        chk("t4_flushed", out_valid_o, 0);
        lat_cfg = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (out_valid_o) found = 1;
            else cycle(1, 0, 0);
        end
        chk("t4_resumed", found, 1);
        chk("t4_pc", out_pc_o, 32'h40);
        cycle(1, 0, 0);
        cycle(1, 0, 0);

        // Redirect past the end of memory: single fault entry, then halt
        cycle(1, 1, 32'h1000);
        cycle(1, 0, 0);
        chk("t5_no_req", cap_req, 0);
        chk("t5_valid", out_valid_o, 1);
        chk("t5_fault", out_fault_o, 1);
        chk("t5_instr", out_instr_o, 0);
        chk("t5_pc", out_pc_o, 32'h1000);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        chk("t5_halt_valid", out_valid_o, 0);
        chk("t5_halt_req", cap_req, 0);
        cycle(1, 1, 32'h0);
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (out_valid_o) found = 1;
            else cycle(1, 0, 0);
        end
        chk("t5_resumed", found, 1);
        chk("t5_resume_pc", out_pc_o, 32'h0);

        // Reset while a read waits: outputs cleared, restart at reset PC
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1, 0, 0);
            if (cap_req && !cap_ack) found = 1;
        end
        chk("t6_pending_seen", found, 1);
        rst_i = 1'b0;
        cycle(1, 0, 0);
        chk("t6_valid", out_valid_o, 0);
        chk("t6_pc", out_pc_o, 0);
        chk("t6_instr", out_instr_o, 0);
        chk("t6_fault", out_fault_o, 0);
        rst_i = 1'b1;
        lat_cfg = 0;
        cycle(1, 0, 0);
        chk("t6_restart_req", cap_req, 1);
        chk("t6_restart_addr", cap_addr, 32'h0);

        // Random traffic: wait states, back-pressure, redirects, faults, resets
        lat_rand = 1;
        for (int n = 0; n < 2500; n++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = 32'h1000;
                1:       tgt = 32'hFF8 | 32'($urandom_range(0, 3));
                2:       tgt = $urandom;
                default: tgt = 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3));
            endcase
            rst_i = ($urandom_range(0, 499) != 0);
            cycle(rdy, redir, tgt);
        end
        rst_i = 1'b1;
        chk("liveness", accepted > 600, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
